// File: rtl/up_down_counter_pkg.sv
// Shared constants for counter blocks.
package up_down_counter_pkg;

    localparam int unsigned COUNTER_WIDTH = 4;

endpackage

// File: rtl/up_down_counter.sv
// Loadable up/down binary counter with a registered output.
// Priority per edge: reset, then load, then step up or down.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] step;

    // Carry and borrow fall off the top; wrap is silent.
    always_comb begin
        step = count;
        if (up_down)
            step = count + 1'b1;
        else
            step = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= data;
        else
            count <= step;
    end

`ifndef SYNTHESIS
    if (WIDTH < 1) begin : g_bad_width
        $error("up_down_counter: WIDTH must be >= 1");
    end
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Directed, table-driven bench for up_down_counter.
module tb_up_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         up_down;
    logic [W-1:0] data;
    logic [W-1:0] count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic         reset;
        logic         load;
        logic         up_down;
        logic [W-1:0] data;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[$];

    up_down_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .up_down (up_down),
        .data    (data),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: count=%0d expected=%0d", name, got, exp);
    endtask

    task automatic add(input logic r, input logic l, input logic u,
                       input logic [W-1:0] d, input logic [W-1:0] e,
                       input string n);
        vec_t v;
        v.reset = r;
        v.load = l;
        v.up_down = u;
        v.data = d;
        v.exp = e;
        v.name = n;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic l, input logic u,
                         input logic [W-1:0] d);
        reset = r;
        load = l;
        up_down = u;
        data = d;
    endtask

    logic [W-1:0] held;

    initial begin
        // reset load up_down data expected
        add(1, 1, 1, 4'd8,  4'd0,  "reset0");
        add(1, 1, 1, 4'd8,  4'd0,  "reset1");
        add(0, 1, 0, 4'd13, 4'd13, "load13");
        add(0, 0, 0, 4'd15, 4'd12, "noload_dec");
        add(0, 1, 1, 4'd14, 4'd14, "load14");
        add(0, 0, 1, 4'd0,  4'd15, "up15");
        add(0, 0, 1, 4'd0,  4'd0,  "upwrap0");
        add(0, 0, 1, 4'd0,  4'd1,  "up1");
        add(0, 1, 0, 4'd1,  4'd1,  "load1");
        add(0, 0, 0, 4'd0,  4'd0,  "dn0");
        add(0, 0, 0, 4'd0,  4'd15, "dnwrap15");
        add(0, 0, 0, 4'd0,  4'd14, "dn14");
        add(0, 1, 1, 4'd5,  4'd5,  "load5");
        add(0, 0, 1, 4'd0,  4'd6,  "dir_up6");
        add(0, 0, 0, 4'd0,  4'd5,  "dir_dn5");
        add(0, 0, 0, 4'd0,  4'd4,  "dir_dn4");
        add(0, 1, 1, 4'd8,  4'd8,  "load8");
        add(0, 0, 1, 4'd0,  4'd9,  "up9");
        add(1, 0, 1, 4'd3,  4'd0,  "reset_mid");
        add(0, 0, 1, 4'd0,  4'd1,  "resume1");
        add(0, 0, 1, 4'd0,  4'd2,  "resume2");
        add(0, 1, 0, 4'd0,  4'd0,  "load0");
        add(0, 1, 0, 4'd15, 4'd15, "load15");
        add(0, 0, 1, 4'd7,  4'd0,  "wrap_ff");

        drive(1, 0, 0, '0);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].reset, vecs[i].load, vecs[i].up_down, vecs[i].data);
            @(posedge clk);
            #1;
            check(vecs[i].name, count, vecs[i].exp);
            @(negedge clk);
        end

        // Input churn between edges must not disturb the register.
        drive(0, 1, 1, 4'd10);
        @(posedge clk);
        #1;
        check("load10", count, 4'd10);
        held = count;
        drive(1, 1, 0, 4'd3);
        #2;
        drive(0, 1, 1, 4'd6);
        #2;
        check("no_comb_path", count, 4'd10);
        drive(0, 0, 0, 4'd9);
        @(posedge clk);
        #1;
        check("dec_after_churn", count, 4'd9);

        // Long run up through a full wrap.
        drive(1, 0, 1, '0);
        @(posedge clk);
        #1;
        drive(0, 0, 1, '0);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            check("full_up", count, 4'(k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
